multiword_adder_seq: RTL and testbench

- Sequences a single adder32 instance across multi-limb operands, giving arbitrary-precision add (up to MAX_WORDS x 32 bits).
- Operand limbs arrive least-significant first on a valid/ready stream. Sum limbs leave on a registered valid/ready stream.
- The inter-limb carry is held in a register between beats.
- Sits between the ALU operand fetch and the writeback path in the ALU subsystem.

---
 rtl/multiword_adder_pkg.sv | 10 +
 rtl/multiword_adder_seq_if.sv | 29 ++
 rtl/adder32.sv | 14 +
 rtl/multiword_adder_seq.sv | 114 +++++++++++
 tb/tb_multiword_adder_seq.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multiword_adder_pkg.sv
// Shared types and constants for the multi-limb adder sequencer.
package multiword_adder_pkg;
   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam int WORD_W        = 32;
   localparam int MAX_WORDS_DEF = 8;
endpackage

// File: rtl/multiword_adder_seq_if.sv
// Operand-limb input stream, sum-limb output stream and status of the limb sequencer.
interface multiword_adder_seq_if;
   import multiword_adder_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_a;
   logic [WORD_W-1:0] in_b;
   logic              in_first;
   logic              in_last;
   logic              in_sub;
   logic              out_valid;
   logic              out_ready;
   logic [WORD_W-1:0] out_s;
   logic              out_last;
   logic              out_cout;
   logic              busy;
   logic              err;

   modport master (
      output in_valid, in_a, in_b, in_first, in_last, in_sub, out_ready,
      input  in_ready, out_valid, out_s, out_last, out_cout, busy, err
   );

   modport slave (
      input  in_valid, in_a, in_b, in_first, in_last, in_sub, out_ready,
      output in_ready, out_valid, out_s, out_last, out_cout, busy, err
   );
endinterface

// File: rtl/adder32.sv
// 32-bit ripple adder with carry in/out; the datapath of the limb sequencer.
// Latency: combinational.
// Backpressure: none.
module adder32
   import multiword_adder_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic              cin,
   output logic [WORD_W-1:0] s,
   output logic              cout
);
   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};
endmodule

// File: rtl/multiword_adder_seq.sv
// Arbitrary-precision add by sequencing one adder32 over LSB-first limbs; A-B with MULTIWORD_ADDER_SEQ_SUB_EN.
// Latency: one cycle from limb accept to registered sum limb.
// Backpressure: in_ready = !out_valid || out_ready; outputs hold while stalled.
module multiword_adder_seq
   import multiword_adder_pkg::*;
#(
   parameter int MAX_WORDS = MAX_WORDS_DEF,
   parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   multiword_adder_seq_if.slave bus
);
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              carry_q, carry_d;
   logic              sub_q, sub_d;
   logic              err_q, err_d;
   logic              accept, emit;
   logic [WORD_W-1:0] b_eff, sum;
   logic              cin, cout;
   logic              out_valid_q, out_last_q, out_cout_q;
   logic [WORD_W-1:0] out_s_q;

   assign bus.in_ready  = !out_valid_q || bus.out_ready;
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_s     = out_s_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_cout  = out_cout_q;
   assign bus.busy      = (state_q == ACTIVE);
   assign bus.err       = err_q;

`ifdef MULTIWORD_ADDER_SEQ_SUB_EN
   logic sub_eff;
   // The first limb carries the mode; later limbs reuse the latched one.
   assign sub_eff = bus.in_first ? bus.in_sub : sub_q;
   assign b_eff   = sub_eff ? ~bus.in_b : bus.in_b;
   assign cin     = bus.in_first ? bus.in_sub : carry_q;
`else
   logic unused_sub;
   assign unused_sub = bus.in_sub ^ sub_q;
   assign b_eff      = bus.in_b;
   assign cin        = bus.in_first ? 1'b0 : carry_q;
`endif

   adder32 u_adder (
      .a    (bus.in_a),
      .b    (b_eff),
      .cin  (cin),
      .s    (sum),
      .cout (cout)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      sub_d   = sub_q;
      err_d   = err_q;
      emit    = 1'b0;
      if (accept) begin
         if (bus.in_first) begin
            // A first limb inside an open operation abandons it and restarts.
            if (state_q == ACTIVE) err_d = 1'b1;
            emit    = 1'b1;
            cnt_d   = CNT_W'(1);
            sub_d   = bus.in_sub;
            carry_d = cout;
            state_d = bus.in_last ? IDLE : ACTIVE;
         end else if (state_q == IDLE) begin
            err_d = 1'b1;
         end else if (cnt_q == CNT_W'(MAX_WORDS)) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            carry_d = 1'b0;
            state_d = IDLE;
         end else begin
            emit    = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            carry_d = bus.in_last ? 1'b0 : cout;
            state_d = bus.in_last ? IDLE : ACTIVE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         sub_q       <= 1'b0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_s_q     <= '0;
         out_last_q  <= 1'b0;
         out_cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         sub_q   <= sub_d;
         err_q   <= err_d;
         if (emit) begin
            out_valid_q <= 1'b1;
            out_s_q     <= sum;
            out_last_q  <= bus.in_last;
            out_cout_q  <= cout;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_multiword_adder_seq.sv
// Directed and random checks of multiword_adder_seq; beats are {s, cout, last}.
module tb_multiword_adder_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          total = 0;
   int          bad = 0;
   logic [33:0] got_q[$];

   multiword_adder_seq_if bus();
   multiword_adder_seq dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   always @(negedge clk)
      if (!rst && bus.out_valid && bus.out_ready)
         got_q.push_back({bus.out_s, bus.out_cout, bus.out_last});

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      got_q.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b,
                       input logic first, input logic last, input logic sub);
      bus.in_a = a; bus.in_b = b; bus.in_first = first;
      bus.in_last = last; bus.in_sub = sub; bus.in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            return;
         end
      end
      total++; bad++;
      $display("FAIL send_timeout got=in_ready_low want=accept");
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [37:0] want;
      want = {1'b1, 1'b0, 32'h0, 4'b0000};
      idle(2);
      total++;
      if ({bus.in_ready, bus.out_valid, bus.out_s, bus.out_last, bus.out_cout, bus.busy, bus.err} !== want) begin
         bad++;
         $display("FAIL reset_held got=%h want=%h",
                  {bus.in_ready, bus.out_valid, bus.out_s, bus.out_last, bus.out_cout, bus.busy, bus.err}, want);
      end
      rst = 1'b0;
      idle(1);
      total++;
      if ({bus.in_ready, bus.out_valid, bus.out_s, bus.out_last, bus.out_cout, bus.busy, bus.err} !== want) begin
         bad++;
         $display("FAIL reset_released got=%h want=%h",
                  {bus.in_ready, bus.out_valid, bus.out_s, bus.out_last, bus.out_cout, bus.busy, bus.err}, want);
      end
   endtask

   task automatic test_single();
      got_q.delete();
      send(32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1, 1'b0);
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b want=0", bus.busy); end
      idle(3);
      total++;
      if (got_q.size() != 1 || got_q[0] !== {32'h0, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL single_beat got=%h (n=%0d) want=%h", got_q.size() > 0 ? got_q[0] : 34'h0,
                  got_q.size(), {32'h0, 1'b1, 1'b1});
      end
   endtask

   task automatic test_two_limb();
      logic [33:0] exp [2] = '{{32'h0, 1'b1, 1'b0}, {32'h1, 1'b0, 1'b1}};
      got_q.delete();
      send(32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0);
      total++;
      if (bus.busy !== 1'b1) begin bad++; $display("FAIL two_busy_open got=%b want=1", bus.busy); end
      send(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      total++;
      if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL two_after_last got=valid%b busy%b want=valid1 busy0", bus.out_valid, bus.busy);
      end
      idle(3);
      total++;
      if (got_q.size() != 2) begin bad++; $display("FAIL two_count got=%0d want=2", got_q.size()); end
      for (int i = 0; i < 2 && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp[i]) begin bad++; $display("FAIL two_beat%0d got=%h want=%h", i, got_q[i], exp[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [33:0] exp [3] = '{{32'h3, 1'b0, 1'b0}, {32'h7, 1'b0, 1'b0}, {32'hB, 1'b0, 1'b1}};
      got_q.delete();
      send(32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
      send(32'h3, 32'h4, 1'b0, 1'b0, 1'b0);
      send(32'h5, 32'h6, 1'b0, 1'b1, 1'b0);
      idle(3);
      total++;
      if (got_q.size() != 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", got_q.size()); end
      for (int i = 0; i < 3 && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp[i]) begin bad++; $display("FAIL b2b_beat%0d got=%h want=%h", i, got_q[i], exp[i]); end
      end
   endtask

   task automatic test_backpressure();
      logic [33:0] exp [4] = '{{32'h0, 1'b1, 1'b0}, {32'h0, 1'b1, 1'b0},
                               {32'h6, 1'b0, 1'b0}, {32'hF, 1'b0, 1'b1}};
      got_q.delete();
      bus.out_ready = 1'b1;
      send(32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0);
      bus.out_ready = 1'b0;
      bus.in_a = 32'hFFFF_FFFF; bus.in_b = 32'h0; bus.in_first = 1'b0; bus.in_last = 1'b0;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc%0d got=%b want=0", c, bus.in_ready); end
         total++;
         if ({bus.out_valid, bus.out_s, bus.out_cout} !== {1'b1, 32'h0, 1'b1}) begin
            bad++; $display("FAIL bp_hold cyc%0d got=%h want=%h", c, {bus.out_valid, bus.out_s, bus.out_cout},
                            {1'b1, 32'h0, 1'b1});
         end
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      send(32'h5, 32'h0, 1'b0, 1'b0, 1'b0);
      send(32'h7, 32'h8, 1'b0, 1'b1, 1'b0);
      idle(3);
      total++;
      if (got_q.size() != 4) begin bad++; $display("FAIL bp_count got=%0d want=4", got_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp[i]) begin bad++; $display("FAIL bp_beat%0d got=%h want=%h", i, got_q[i], exp[i]); end
      end
   endtask

   task automatic test_sub();
`ifdef MULTIWORD_ADDER_SEQ_SUB_EN
      logic [33:0] exp [2] = '{{32'hFFFF_FFFF, 1'b0, 1'b0}, {32'h0, 1'b1, 1'b1}};
`else
      logic [33:0] exp [2] = '{{32'h1, 1'b0, 1'b0}, {32'h1, 1'b0, 1'b1}};
`endif
      got_q.delete();
      send(32'h0, 32'h1, 1'b1, 1'b0, 1'b1);
      send(32'h1, 32'h0, 1'b0, 1'b1, 1'b0);
      idle(3);
      total++;
      if (got_q.size() != 2) begin bad++; $display("FAIL sub_count got=%0d want=2", got_q.size()); end
      for (int i = 0; i < 2 && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp[i]) begin bad++; $display("FAIL sub_beat%0d got=%h want=%h", i, got_q[i], exp[i]); end
      end
   endtask

   task automatic test_err_no_first();
      do_reset();
      send(32'h5, 32'h6, 1'b0, 1'b0, 1'b0);
      idle(3);
      total++;
      if (got_q.size() != 0 || bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL nofirst_output got=n%0d valid%b want=n0 valid0", got_q.size(), bus.out_valid);
      end
      total++;
      if (bus.err !== 1'b1) begin bad++; $display("FAIL nofirst_err got=%b want=1", bus.err); end
   endtask

   task automatic test_err_overflow();
      do_reset();
      for (int i = 0; i < 8; i++) send(32'(i), 32'(i), i == 0, 1'b0, 1'b0);
      total++;
      if (bus.err !== 1'b0) begin bad++; $display("FAIL ovf_err_early got=%b want=0", bus.err); end
      send(32'h9, 32'h9, 1'b0, 1'b1, 1'b0);
      idle(3);
      total++;
      if (got_q.size() != 8) begin bad++; $display("FAIL ovf_count got=%0d want=8", got_q.size()); end
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== {32'(2 * i), 1'b0, 1'b0}) begin
            bad++; $display("FAIL ovf_beat%0d got=%h want=%h", i, got_q[i], {32'(2 * i), 1'b0, 1'b0});
         end
      end
      total++;
      if ({bus.err, bus.busy} !== 2'b10) begin bad++; $display("FAIL ovf_state got=err%b busy%b want=err1 busy0", bus.err, bus.busy); end
   endtask

   task automatic test_reset_mid();
      logic [37:0] want;
      logic [33:0] exp [2] = '{{32'h2, 1'b0, 1'b0}, {32'h0, 1'b0, 1'b1}};
      want = {1'b1, 1'b0, 32'h0, 4'b0000};
      do_reset();
      send(32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0);
      send(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0);
      bus.in_a = 32'h3; bus.in_b = 32'h4; bus.in_first = 1'b0; bus.in_last = 1'b0;
      bus.in_valid = 1'b1;
      #2 rst = 1'b1;
      #1;
      total++;
      if ({bus.in_ready, bus.out_valid, bus.out_s, bus.out_last, bus.out_cout, bus.busy, bus.err} !== want) begin
         bad++;
         $display("FAIL midrst_outputs got=%h want=%h",
                  {bus.in_ready, bus.out_valid, bus.out_s, bus.out_last, bus.out_cout, bus.busy, bus.err}, want);
      end
      bus.in_valid = 1'b0;
      idle(1);
      rst = 1'b0;
      got_q.delete();
      send(32'h1, 32'h1, 1'b1, 1'b0, 1'b0);
      send(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      idle(3);
      total++;
      if (got_q.size() != 2) begin bad++; $display("FAIL midrst_count got=%0d want=2", got_q.size()); end
      for (int i = 0; i < 2 && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp[i]) begin bad++; $display("FAIL midrst_beat%0d got=%h want=%h", i, got_q[i], exp[i]); end
      end
   endtask

   task automatic test_random();
      logic [33:0]  exp_q[$];
      logic [256:0] a_w, b_w, mask, part, sum, sum_sh;
      logic [31:0]  la, lb;
      bit           drv_done;
      int           n;
      drv_done = 1'b0;
      do_reset();
      fork
         begin
            for (int op = 0; op < 1000; op++) begin
               n = $urandom_range(1, 8);
               a_w = '0; b_w = '0;
               for (int i = 0; i < n; i++) begin
                  la = $urandom; lb = $urandom;
                  if ($urandom_range(0, 3) == 0) lb = ~la;
                  a_w[32*i +: 32] = la; b_w[32*i +: 32] = lb;
               end
               sum = a_w + b_w;
               for (int i = 0; i < n; i++) begin
                  mask = (257'd1 << (32 * (i + 1))) - 257'd1;
                  part = ((a_w & mask) + (b_w & mask)) >> (32 * (i + 1));
                  sum_sh = sum >> (32 * i);
                  exp_q.push_back({sum_sh[31:0], part[0], i == n - 1});
               end
               for (int i = 0; i < n; i++) begin
                  if ($urandom_range(0, 3) == 0) idle(1);
                  send(a_w[32*i +: 32], b_w[32*i +: 32], i == 0, i == n - 1, 1'b0);
               end
            end
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               @(posedge clk); #1;
               bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = 1'b1;
         end
      join
      for (int c = 0; c < 500 && got_q.size() < exp_q.size(); c++) idle(1);
      total++;
      if (got_q.size() != exp_q.size()) begin
         bad++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
      end
      total++;
      if (bus.err !== 1'b0) begin bad++; $display("FAIL rand_err got=%b want=0", bus.err); end
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_first = 1'b0;
      bus.in_last = 1'b0; bus.in_sub = 1'b0; bus.out_ready = 1'b1;
      test_reset();
      test_single();
      test_two_limb();
      test_back_to_back();
      test_backpressure();
      test_sub();
      test_err_no_first();
      test_err_overflow();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
